// File: rtl/chain_score_reduce_if.sv
// Handshake bundle for chain_score_reduce.
// master drives beats/ready; slave is the reducer.
interface chain_score_reduce_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 16,
  parameter int CNT_W  = 7
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_score;
  logic [DATA_W-1:0] in_f_prev;
  logic [IDX_W-1:0]  in_idx;
  logic [DATA_W-1:0] in_w;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_f;
  logic [IDX_W-1:0]  out_pred;
  logic [CNT_W-1:0]  out_cnt;
  logic              out_ovf;

  modport master (
    output in_valid, in_score, in_f_prev,
    output in_idx, in_w, in_last, out_ready,
    input  in_ready, out_valid, out_f,
    input  out_pred, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_score, in_f_prev,
    input  in_idx, in_w, in_last, out_ready,
    output in_ready, out_valid, out_f,
    output out_pred, out_cnt, out_ovf
  );
endinterface

// File: rtl/chain_score_reduce.sv
// Reduces per-predecessor beats to f(i) and best j.
// CHAIN_SCORE_REDUCE_SAT_EN: saturate cand instead of wrap.
module chain_score_reduce #(
  parameter  int DATA_W   = 32,
  parameter  int IDX_W    = 16,
  parameter  int MAX_PRED = 64,
  localparam int CNT_W    = $clog2(MAX_PRED + 1)
) (
  input logic clk,
  input logic reset,
  chain_score_reduce_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] best_q, best_d;
  logic [IDX_W-1:0]  pred_q, pred_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic              accept;
  logic              idle;
  logic              sentinel;
  logic              better;
  logic              at_max;
  logic [DATA_W-1:0] cand;
  logic [DATA_W-1:0] base;
  logic [IDX_W-1:0]  base_pred;
  logic [CNT_W-1:0]  base_cnt;
  logic              base_ovf;

  localparam logic [DATA_W-1:0] SENT =
    {1'b1, {(DATA_W-1){1'b0}}};

  assign idle   = (state_q == IDLE);
  assign accept = bus.in_valid && (state_q != HOLD);

  assign sentinel = (bus.in_score == SENT);

`ifdef CHAIN_SCORE_REDUCE_SAT_EN
  localparam logic [DATA_W:0] MAX_W =
    {2'b00, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W:0] MIN_W =
    {2'b11, {(DATA_W-2){1'b0}}, 1'b1};

  logic [DATA_W:0] sum_wide;

  assign sum_wide =
    {bus.in_f_prev[DATA_W-1], bus.in_f_prev} +
    {bus.in_score[DATA_W-1], bus.in_score};

  // clamp the wide sum into the symmetric range
  always_comb begin
    cand = sum_wide[DATA_W-1:0];
    if ($signed(sum_wide) > $signed(MAX_W))
      cand = MAX_W[DATA_W-1:0];
    else if ($signed(sum_wide) < $signed(MIN_W))
      cand = MIN_W[DATA_W-1:0];
  end
`else
  assign cand = bus.in_f_prev + bus.in_score;
`endif

  // first beat of an anchor starts from W, not the old best
  assign base      = idle ? bus.in_w : best_q;
  assign base_pred = idle ? {IDX_W{1'b1}} : pred_q;
  assign base_cnt  = idle ? '0 : cnt_q;
  assign base_ovf  = idle ? 1'b0 : ovf_q;
  assign at_max    = (base_cnt == CNT_W'(MAX_PRED));

  assign better = !sentinel &&
                  ($signed(cand) > $signed(base));

  // next accumulator values for an accepted beat
  always_comb begin
    best_d = base;
    pred_d = base_pred;
    cnt_d  = at_max ? base_cnt : base_cnt + CNT_W'(1);
    ovf_d  = base_ovf | at_max;
    if (better) begin
      best_d = cand;
      pred_d = bus.in_idx;
    end
  end

  // accumulators double as the registered result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_q <= '0;
      pred_q <= '1;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      best_q <= best_d;
      pred_q <= pred_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept)
          state_d = bus.in_last ? HOLD : ACCUM;
      end
      ACCUM: begin
        if (accept && bus.in_last)
          state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_f     = best_q;
  assign bus.out_pred  = pred_q;
  assign bus.out_cnt   = cnt_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_chain_score_reduce.sv
// Directed bench for chain_score_reduce.
// Uses MAX_PRED=4 so saturation is reachable.
module tb_chain_score_reduce;

  localparam int DW = 32;
  localparam int IW = 16;
  localparam int MP = 4;
  localparam int CW = $clog2(MP + 1);

  logic clk;
  logic reset;

  int total;
  int bad;

  chain_score_reduce_if #(
    .DATA_W(DW), .IDX_W(IW), .CNT_W(CW)
  ) bus ();

  chain_score_reduce #(
    .DATA_W(DW), .IDX_W(IW), .MAX_PRED(MP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      w;
    int               n;
    logic [2:0][31:0] f;
    logic [2:0][31:0] s;
    logic [2:0][15:0] j;
    logic [31:0]      ef;
    logic [15:0]      ep;
    int               ec;
  } vec_t;

  vec_t v[7];

  function automatic vec_t mk(
    logic [31:0] w, int n,
    logic [31:0] f0, logic [31:0] s0, logic [15:0] j0,
    logic [31:0] f1, logic [31:0] s1, logic [15:0] j1,
    logic [31:0] f2, logic [31:0] s2, logic [15:0] j2,
    logic [31:0] ef, logic [15:0] ep, int ec
  );
    vec_t r;
    r.w  = w;
    r.n  = n;
    r.f  = {f2, f1, f0};
    r.s  = {s2, s1, s0};
    r.j  = {j2, j1, j0};
    r.ef = ef;
    r.ep = ep;
    r.ec = ec;
    return r;
  endfunction

  task automatic chk(string nm,
                     logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h",
               nm, act, exp);
    end
  endtask

  task automatic beat(logic [31:0] w,
                      logic [31:0] f,
                      logic [31:0] s,
                      logic [15:0] j,
                      logic last);
    bus.in_valid  = 1'b1;
    bus.in_w      = w;
    bus.in_f_prev = f;
    bus.in_score  = s;
    bus.in_idx    = j;
    bus.in_last   = last;
    chk("in_ready_beat", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic res(string nm,
                     logic [31:0] ef,
                     logic [15:0] ep,
                     int ec,
                     logic eo);
    chk({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({nm, "_f"},     64'(bus.out_f),     64'(ef));
    chk({nm, "_pred"},  64'(bus.out_pred),  64'(ep));
    chk({nm, "_cnt"},   64'(bus.out_cnt),   64'(ec));
    chk({nm, "_ovf"},   64'(bus.out_ovf),   64'(eo));
  endtask

  task automatic drain(string nm);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({nm, "_drain_valid"}, 64'(bus.out_valid), 64'd0);
    chk({nm, "_drain_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] sat_f;
    logic [15:0] sat_p;
    total = 0;
    bad   = 0;

`ifdef CHAIN_SCORE_REDUCE_SAT_EN
    sat_f = 32'h7FFF_FFFF;
    sat_p = 16'd3;
`else
    sat_f = 32'd0;
    sat_p = 16'hFFFF;
`endif

    v[0] = mk(32'd40, 3,
              32'd100, -32'sd10, 16'd5,
              32'd50,  32'd20,   16'd7,
              32'd120, -32'sd60, 16'd9,
              32'd90, 16'd5, 3);
    v[1] = mk(32'd40, 2,
              32'd10, 32'd5,     16'd2,
              32'd20, -32'sd30,  16'd1,
              32'd0,  32'd0,     16'd0,
              32'd40, 16'hFFFF, 2);
    v[2] = mk(32'd0, 2,
              32'd80, 32'd10, 16'd5,
              32'd60, 32'd30, 16'd3,
              32'd0,  32'd0,  16'd0,
              32'd90, 16'd5, 2);
    v[3] = mk(32'd40, 1,
              32'd500, 32'h8000_0000, 16'd4,
              32'd0,   32'd0,         16'd0,
              32'd0,   32'd0,         16'd0,
              32'd40, 16'hFFFF, 1);
    v[4] = mk(32'd0, 1,
              32'h7FFF_FFF0, 32'h100, 16'd3,
              32'd0, 32'd0, 16'd0,
              32'd0, 32'd0, 16'd0,
              sat_f, sat_p, 1);
    v[5] = mk(-32'sd100, 2,
              -32'sd50,  -32'sd20, 16'd2,
              -32'sd200, 32'd150,  16'd6,
              32'd0, 32'd0, 16'd0,
              -32'sd50, 16'd6, 2);
    v[6] = mk(32'd5, 3,
              32'd1,  32'd1,    16'd1,
              32'd3,  32'd3,    16'd2,
              32'd10, -32'sd1,  16'd3,
              32'd9, 16'd3, 3);

    bus.in_valid  = 1'b0;
    bus.in_score  = '0;
    bus.in_f_prev = '0;
    bus.in_idx    = '0;
    bus.in_w      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_f",     64'(bus.out_f),     64'd0);
    chk("rst_pred",  64'(bus.out_pred),  64'hFFFF);
    chk("rst_cnt",   64'(bus.out_cnt),   64'd0);
    chk("rst_ovf",   64'(bus.out_ovf),   64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < v[i].n; b++) begin
        beat(v[i].w, v[i].f[b], v[i].s[b],
             v[i].j[b], b == v[i].n - 1);
        if (i % 2 == 1 && b == 0 && v[i].n > 1) begin
          @(posedge clk);
          #1;
          chk("gap_valid", 64'(bus.out_valid), 64'd0);
        end
      end
      res($sformatf("vec%0d", i),
          v[i].ef, v[i].ep, v[i].ec, 1'b0);
      drain($sformatf("vec%0d", i));
    end

    // backpressure: result held, stray beats refused
    beat(32'd40, 32'd100, -32'sd10, 16'd5, 1'b0);
    beat(32'd40, 32'd50,  32'd20,   16'd7, 1'b0);
    beat(32'd40, 32'd120, -32'sd60, 16'd9, 1'b1);
    bus.in_valid  = 1'b1;
    bus.in_f_prev = 32'd1000;
    bus.in_score  = 32'd0;
    bus.in_idx    = 16'd99;
    bus.in_last   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_ready", 64'(bus.in_ready),  64'd0);
      chk("bp_f",     64'(bus.out_f),     64'd90);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    res("bp_hold", 32'd90, 16'd5, 3, 1'b0);
    drain("bp");
    beat(32'd40, 32'd0, 32'd5, 16'd1, 1'b1);
    res("bp_next", 32'd40, 16'hFFFF, 1, 1'b0);
    drain("bp_next");

    // overflow: seven beats against MAX_PRED=4
    for (int i = 0; i < 7; i++)
      beat(32'd0, 32'(i), 32'd0, 16'(i), i == 6);
    res("ovf", 32'd6, 16'd6, 4, 1'b1);
    drain("ovf");

    // exactly MAX_PRED beats: saturated, no overflow
    for (int i = 1; i <= 4; i++)
      beat(32'd0, 32'(i), 32'd0, 16'(i), i == 4);
    res("full", 32'd4, 16'd4, 4, 1'b0);
    drain("full");

    // reset in the middle of an anchor
    beat(32'd40, 32'd100, 32'd1, 16'd2, 1'b0);
    beat(32'd40, 32'd100, 32'd2, 16'd3, 1'b0);
    reset = 1'b0;
    #1;
    chk("racc_valid", 64'(bus.out_valid), 64'd0);
    chk("racc_cnt",   64'(bus.out_cnt),   64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    beat(32'd40, 32'd0, 32'd5, 16'd1, 1'b1);
    res("racc_next", 32'd40, 16'hFFFF, 1, 1'b0);

    // reset while a result is pending
    reset = 1'b0;
    #1;
    chk("rhold_valid", 64'(bus.out_valid), 64'd0);
    chk("rhold_f",     64'(bus.out_f),     64'd0);
    chk("rhold_pred",  64'(bus.out_pred),  64'hFFFF);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rhold_ready", 64'(bus.in_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
